// File: rtl/gc_controller_poller.sv
// gc_controller_poller: polls a GameCube controller over its open-drain
// single-wire bus at a fixed rate and decodes each 64-bit status reply into
// registered button, stick and trigger outputs.
module gc_controller_poller #(
    parameter int unsigned US_CYCLES      = 100,
    parameter int unsigned POLL_CYCLES    = 1_666_667,
    parameter int unsigned TIMEOUT_CYCLES = 1_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       gc_data_in,
    output logic       gc_data_oe,
    output logic       A,
    output logic       B,
    output logic       X,
    output logic       Y,
    output logic       start_pause,
    output logic       L,
    output logic       R,
    output logic       Z,
    output logic       D_UP,
    output logic       D_DOWN,
    output logic       D_RIGHT,
    output logic       D_LEFT,
    output logic [7:0] JOY_X,
    output logic [7:0] JOY_Y,
    output logic [7:0] C_STICK_X,
    output logic [7:0] C_STICK_Y,
    output logic [7:0] L_TRIGGER,
    output logic [7:0] R_TRIGGER,
    output logic       frame_valid,
    output logic       frame_error,
    output logic       connected
);

    localparam int unsigned BIT_CYCLES = 4 * US_CYCLES;
    localparam int unsigned CW = $clog2(BIT_CYCLES);
    localparam int unsigned PW = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [CW-1:0] BIT_LAST    = CW'(BIT_CYCLES - 1);
    localparam logic [CW-1:0] SHORT_LOW   = CW'(US_CYCLES);
    localparam logic [CW-1:0] LONG_LOW    = CW'(3 * US_CYCLES);
    localparam logic [CW-1:0] SAMPLE_AT   = CW'(2 * US_CYCLES - 1);
    localparam logic [PW-1:0] POLL_LAST   = PW'(POLL_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST     = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [24:0]   CMD_WORD    = {24'h400300, 1'b1};
    localparam logic [6:0]    TX_LAST_BIT = 7'd24;
    localparam logic [6:0]    RX_LAST_BIT = 7'd63;

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        RX_WAIT,
        RX_BIT,
        DECODE,
        ERROR
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   poll_q;
    logic            poll_wrap;
    logic            sync1_q, sync2_q, prev_q;
    logic            fall;
    logic [CW-1:0]   cyc_q;
    logic [TW-1:0]   to_q;
    logic [6:0]      cnt_q;
    logic [24:0]     tx_q;
    logic [63:0]     rx_q;
    logic            frame_ok;
    logic            load_en;
    logic            err_en;

    logic [4:0]      btn0_q;
    logic [6:0]      btn1_q;
    logic [7:0]      joy_x_q, joy_y_q, c_x_q, c_y_q, l_trig_q, r_trig_q;
    logic            frame_valid_q, frame_error_q, connected_q;

    assign poll_wrap = (poll_q == POLL_LAST);
    assign fall      = prev_q & ~sync2_q;
    assign frame_ok  = (rx_q[63:61] == 3'b000) && rx_q[55];

    // Free-running poll-period counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            poll_q <= '0;
        end else if (poll_wrap) begin
            poll_q <= '0;
        end else begin
            poll_q <= poll_q + PW'(1);
        end
    end

    // Two-flop synchroniser for the raw bus plus one delay stage for edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= gc_data_in;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (poll_wrap) state_d = SEND;
            end
            SEND: begin
                if (cyc_q == BIT_LAST && cnt_q == TX_LAST_BIT) state_d = RX_WAIT;
            end
            RX_WAIT: begin
                if (fall) begin
                    state_d = RX_BIT;
                end else if (to_q == TO_LAST) begin
                    state_d = ERROR;
                end
            end
            RX_BIT: begin
                if (cyc_q == SAMPLE_AT) begin
                    state_d = (cnt_q == RX_LAST_BIT) ? DECODE : RX_WAIT;
                end
            end
            DECODE: begin
                state_d = frame_ok ? IDLE : ERROR;
            end
            ERROR: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM outputs: bus drive and the decode/error strobes for the output registers.
    always_comb begin
        gc_data_oe = 1'b0;
        load_en    = 1'b0;
        err_en     = 1'b0;
        case (state_q)
            SEND:    gc_data_oe = (cyc_q < (tx_q[24] ? SHORT_LOW : LONG_LOW));
            DECODE:  load_en    = frame_ok;
            ERROR:   err_en     = 1'b1;
            default: begin end
        endcase
    end

    // Bit timing, timeout counting and the transmit/receive shift registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            cyc_q <= '0;
            to_q  <= '0;
            cnt_q <= '0;
            tx_q  <= '0;
            rx_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    cyc_q <= '0;
                    to_q  <= '0;
                    cnt_q <= '0;
                    tx_q  <= CMD_WORD;
                end
                SEND: begin
                    to_q <= '0;
                    if (cyc_q == BIT_LAST) begin
                        cyc_q <= '0;
                        tx_q  <= {tx_q[23:0], 1'b0};
                        // Bit index doubles as the reply bit counter, so clear it on the way out.
                        cnt_q <= (cnt_q == TX_LAST_BIT) ? '0 : cnt_q + 7'd1;
                    end else begin
                        cyc_q <= cyc_q + CW'(1);
                    end
                end
                RX_WAIT: begin
                    cyc_q <= '0;
                    to_q  <= to_q + TW'(1);
                end
                RX_BIT: begin
                    to_q  <= '0;
                    cyc_q <= cyc_q + CW'(1);
                    if (cyc_q == SAMPLE_AT) begin
                        rx_q  <= {rx_q[62:0], sync2_q};
                        cnt_q <= cnt_q + 7'd1;
                    end
                end
                default: begin
                    cyc_q <= '0;
                    to_q  <= '0;
                end
            endcase
        end
    end

    // Registered decoded outputs and status flags; data changes only on a good frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            btn0_q        <= '0;
            btn1_q        <= '0;
            joy_x_q       <= 8'd128;
            joy_y_q       <= 8'd128;
            c_x_q         <= 8'd128;
            c_y_q         <= 8'd128;
            l_trig_q      <= '0;
            r_trig_q      <= '0;
            frame_valid_q <= 1'b0;
            frame_error_q <= 1'b0;
            connected_q   <= 1'b0;
        end else begin
            frame_valid_q <= load_en;
            frame_error_q <= err_en;
            if (load_en) begin
                btn0_q      <= rx_q[60:56];
                btn1_q      <= rx_q[54:48];
                joy_x_q     <= rx_q[47:40];
                joy_y_q     <= rx_q[39:32];
                c_x_q       <= rx_q[31:24];
                c_y_q       <= rx_q[23:16];
                l_trig_q    <= rx_q[15:8];
                r_trig_q    <= rx_q[7:0];
                connected_q <= 1'b1;
            end else if (err_en) begin
                connected_q <= 1'b0;
            end
        end
    end

    assign start_pause = btn0_q[4];
    assign Y           = btn0_q[3];
    assign X           = btn0_q[2];
    assign B           = btn0_q[1];
    assign A           = btn0_q[0];
    assign L           = btn1_q[6];
    assign R           = btn1_q[5];
    assign Z           = btn1_q[4];
    assign D_UP        = btn1_q[3];
    assign D_DOWN      = btn1_q[2];
    assign D_RIGHT     = btn1_q[1];
    assign D_LEFT      = btn1_q[0];
    assign JOY_X       = joy_x_q;
    assign JOY_Y       = joy_y_q;
    assign C_STICK_X   = c_x_q;
    assign C_STICK_Y   = c_y_q;
    assign L_TRIGGER   = l_trig_q;
    assign R_TRIGGER   = r_trig_q;
    assign frame_valid = frame_valid_q;
    assign frame_error = frame_error_q;
    assign connected   = connected_q;

endmodule

// File: tb/tb_gc_controller_poller.sv
// Testbench for gc_controller_poller: open-drain bus model with a controller
// reply generator and a queue of expected decoded frames.
module tb_gc_controller_poller;

    localparam int US   = 4;
    localparam int POLL = 2000;
    localparam int TMO  = 40;
    localparam int LIM  = 3000;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       dev_low = 1'b0;
    logic       gc_data_in, gc_data_oe;
    logic       A, B, X, Y, start_pause, L, R, Z, D_UP, D_DOWN, D_RIGHT, D_LEFT;
    logic [7:0] JOY_X, JOY_Y, C_STICK_X, C_STICK_Y, L_TRIGGER, R_TRIGGER;
    logic       frame_valid, frame_error, connected;

    int total = 0;
    int bad   = 0;
    logic [63:0] exp_q[$];

    localparam logic [63:0] RESET_VAL = 64'h0080_8080_8080_0000;

    // Wired-AND bus with pull-up: low if the host or the controller pulls it.
    assign gc_data_in = !(gc_data_oe || dev_low);

    // Decoded outputs arranged in reply-byte order (header bits fixed).
    wire [63:0] obs = {3'b000, start_pause, Y, X, B, A,
                       1'b1, L, R, Z, D_UP, D_DOWN, D_RIGHT, D_LEFT,
                       JOY_X, JOY_Y, C_STICK_X, C_STICK_Y, L_TRIGGER, R_TRIGGER};

    always #5 clk = ~clk;

    gc_controller_poller #(
        .US_CYCLES(US),
        .POLL_CYCLES(POLL),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .reset(reset), .gc_data_in(gc_data_in), .gc_data_oe(gc_data_oe),
        .A(A), .B(B), .X(X), .Y(Y), .start_pause(start_pause),
        .L(L), .R(R), .Z(Z),
        .D_UP(D_UP), .D_DOWN(D_DOWN), .D_RIGHT(D_RIGHT), .D_LEFT(D_LEFT),
        .JOY_X(JOY_X), .JOY_Y(JOY_Y), .C_STICK_X(C_STICK_X), .C_STICK_Y(C_STICK_Y),
        .L_TRIGGER(L_TRIGGER), .R_TRIGGER(R_TRIGGER),
        .frame_valid(frame_valid), .frame_error(frame_error), .connected(connected)
    );

    // Wait for the next poll and return at the end of the 25-bit command (start of RX_WAIT).
    task automatic wait_cmd_done(output bit ok);
        int n;
        int lo;
        int hi;
        ok = 1'b0;
        n = 0;
        while (!gc_data_oe && n < 2 * POLL) begin @(negedge clk); n++; end
        if (!gc_data_oe) return;
        for (int i = 0; i < 25; i++) begin
            lo = 0;
            while (gc_data_oe && lo < 4 * US) begin lo++; @(negedge clk); end
            if (i < 24) begin
                hi = 0;
                while (!gc_data_oe && hi < 4 * US) begin hi++; @(negedge clk); end
            end
        end
        repeat (3 * US) @(negedge clk);
        ok = 1'b1;
    endtask

    // Controller reply: first nbits of data, MSB first, after a short turnaround.
    task automatic send_reply(input logic [63:0] data, input int nbits);
        logic b;
        repeat (2 * US) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            b = data[63 - i];
            dev_low = 1'b1;
            repeat (b ? US : 3 * US) @(negedge clk);
            dev_low = 1'b0;
            repeat (b ? 3 * US : US) @(negedge clk);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        total++; if (gc_data_oe !== 1'b0) begin bad++; $display("FAIL reset_oe: got %b want 0", gc_data_oe); end
        total++; if (obs !== RESET_VAL) begin bad++; $display("FAIL reset_outputs: got %h want %h", obs, RESET_VAL); end
        total++; if ({frame_valid, frame_error, connected} !== 3'b000) begin
            bad++; $display("FAIL reset_flags: got %b want 000", {frame_valid, frame_error, connected});
        end
        reset = 1'b0;
    endtask

    task automatic test_command();
        int n;
        int lo;
        int hi;
        bit widths_ok;
        logic [24:0] cmd;
        logic [24:0] want;
        want = {24'h400300, 1'b1};
        n = 0;
        widths_ok = 1'b1;
        cmd = '0;
        while (!gc_data_oe && n < 2 * POLL) begin @(negedge clk); n++; end
        total++; if (n !== POLL) begin bad++; $display("FAIL poll_start: got %0d want %0d", n, POLL); end
        for (int i = 0; i < 25; i++) begin
            lo = 0;
            while (gc_data_oe && lo < 4 * US) begin lo++; @(negedge clk); end
            cmd = {cmd[23:0], (lo == US)};
            if (lo != US && lo != 3 * US) widths_ok = 1'b0;
            if (i < 24) begin
                hi = 0;
                while (!gc_data_oe && hi < 4 * US) begin hi++; @(negedge clk); end
                if (lo + hi != 4 * US) widths_ok = 1'b0;
            end
        end
        total++; if (cmd !== want) begin bad++; $display("FAIL cmd_bits: got %h want %h", cmd, want); end
        total++; if (widths_ok !== 1'b1) begin bad++; $display("FAIL cmd_timing: got %b want 1", widths_ok); end
    endtask

    task automatic test_good_frame();
        logic [63:0] reply;
        logic [63:0] e;
        bit ok;
        int k;
        reply = 64'h0181_8080_8080_0000;
        wait_cmd_done(ok);
        total++; if (!ok) begin bad++; $display("FAIL good_cmd: got %b want 1", ok); end
        exp_q.push_back(reply);
        fork
            send_reply(reply, 64);
            begin
                k = 0;
                while (!frame_valid && k < LIM) begin @(negedge clk); k++; end
                e = exp_q.pop_front();
                total++; if (frame_valid !== 1'b1) begin bad++; $display("FAIL good_valid: got %b want 1", frame_valid); end
                total++; if (obs !== e) begin bad++; $display("FAIL good_data: got %h want %h", obs, e); end
                total++; if ({A, D_LEFT, B, start_pause, D_UP} !== 5'b11000) begin
                    bad++; $display("FAIL good_buttons: got %b want 11000", {A, D_LEFT, B, start_pause, D_UP});
                end
                total++; if (connected !== 1'b1) begin bad++; $display("FAIL good_connected: got %b want 1", connected); end
                @(negedge clk);
                total++; if (frame_valid !== 1'b0) begin bad++; $display("FAIL good_pulse: got %b want 0", frame_valid); end
            end
        join
    endtask

    task automatic test_update();
        logic [63:0] reply;
        logic [63:0] prior;
        logic [63:0] e;
        bit ok;
        bit held;
        int k;
        reply = 64'h0080_FF80_8080_007F;
        prior = obs;
        held = 1'b1;
        wait_cmd_done(ok);
        total++; if (!ok) begin bad++; $display("FAIL upd_cmd: got %b want 1", ok); end
        exp_q.push_back(reply);
        fork
            send_reply(reply, 64);
            begin
                k = 0;
                while (!frame_valid && k < LIM) begin
                    if (obs !== prior) held = 1'b0;
                    @(negedge clk); k++;
                end
                e = exp_q.pop_front();
                total++; if (held !== 1'b1) begin bad++; $display("FAIL upd_hold: got %b want 1", held); end
                total++; if (frame_valid !== 1'b1) begin bad++; $display("FAIL upd_valid: got %b want 1", frame_valid); end
                total++; if (obs !== e) begin bad++; $display("FAIL upd_data: got %h want %h", obs, e); end
                total++; if ({JOY_X, R_TRIGGER} !== 16'hFF7F) begin
                    bad++; $display("FAIL upd_fields: got %h want ff7f", {JOY_X, R_TRIGGER});
                end
            end
        join
    endtask

    task automatic test_timeout();
        logic [63:0] prior;
        bit ok;
        bit saw_valid;
        int k;
        prior = obs;
        saw_valid = 1'b0;
        wait_cmd_done(ok);
        total++; if (!ok) begin bad++; $display("FAIL to_cmd: got %b want 1", ok); end
        k = 0;
        while (!frame_error && k < LIM) begin
            @(negedge clk); k++;
            if (frame_valid) saw_valid = 1'b1;
        end
        total++; if (k !== TMO + 1) begin bad++; $display("FAIL to_latency: got %0d want %0d", k, TMO + 1); end
        total++; if (connected !== 1'b0) begin bad++; $display("FAIL to_connected: got %b want 0", connected); end
        total++; if (obs !== prior) begin bad++; $display("FAIL to_hold: got %h want %h", obs, prior); end
        total++; if (saw_valid !== 1'b0) begin bad++; $display("FAIL to_novalid: got %b want 0", saw_valid); end
    endtask

    task automatic test_bad_header();
        logic [63:0] tab [2];
        logic [63:0] prior;
        bit ok;
        bit saw_valid;
        int k;
        tab[0] = 64'h0100_8080_8080_0000;
        tab[1] = 64'h2181_8080_8080_0000;
        for (int t = 0; t < 2; t++) begin
            prior = obs;
            saw_valid = 1'b0;
            wait_cmd_done(ok);
            total++; if (!ok) begin bad++; $display("FAIL hdr_cmd%0d: got %b want 1", t, ok); end
            fork
                send_reply(tab[t], 64);
                begin
                    k = 0;
                    while (!frame_error && k < LIM) begin
                        @(negedge clk); k++;
                        if (frame_valid) saw_valid = 1'b1;
                    end
                    total++; if (frame_error !== 1'b1) begin bad++; $display("FAIL hdr_error%0d: got %b want 1", t, frame_error); end
                    total++; if (saw_valid !== 1'b0) begin bad++; $display("FAIL hdr_novalid%0d: got %b want 0", t, saw_valid); end
                    total++; if (obs !== prior) begin bad++; $display("FAIL hdr_hold%0d: got %h want %h", t, obs, prior); end
                    total++; if (connected !== 1'b0) begin bad++; $display("FAIL hdr_conn%0d: got %b want 0", t, connected); end
                end
            join
        end
    endtask

    task automatic test_truncated();
        logic [63:0] prior;
        logic [63:0] reply;
        logic [63:0] e;
        bit ok;
        int k;
        prior = obs;
        reply = 64'h1FFF_0102_0304_0506;
        wait_cmd_done(ok);
        total++; if (!ok) begin bad++; $display("FAIL trunc_cmd: got %b want 1", ok); end
        fork
            send_reply(64'h1FFF_FFFF_FFFF_FFFF, 40);
            begin
                k = 0;
                while (!frame_error && k < LIM) begin @(negedge clk); k++; end
                total++; if (frame_error !== 1'b1) begin bad++; $display("FAIL trunc_error: got %b want 1", frame_error); end
                total++; if (obs !== prior) begin bad++; $display("FAIL trunc_hold: got %h want %h", obs, prior); end
            end
        join
        wait_cmd_done(ok);
        total++; if (!ok) begin bad++; $display("FAIL recover_cmd: got %b want 1", ok); end
        exp_q.push_back(reply);
        fork
            send_reply(reply, 64);
            begin
                k = 0;
                while (!frame_valid && k < LIM) begin @(negedge clk); k++; end
                e = exp_q.pop_front();
                total++; if (frame_valid !== 1'b1) begin bad++; $display("FAIL recover_valid: got %b want 1", frame_valid); end
                total++; if (obs !== e) begin bad++; $display("FAIL recover_data: got %h want %h", obs, e); end
                total++; if (connected !== 1'b1) begin bad++; $display("FAIL recover_conn: got %b want 1", connected); end
            end
        join
    endtask

    task automatic test_reset_mid();
        bit ok;
        int n;
        wait_cmd_done(ok);
        total++; if (!ok) begin bad++; $display("FAIL rst_cmd: got %b want 1", ok); end
        send_reply(64'h0181_8080_8080_0000, 30);
        reset = 1'b1;
        @(negedge clk);
        total++; if (obs !== RESET_VAL) begin bad++; $display("FAIL rst_mid_outputs: got %h want %h", obs, RESET_VAL); end
        total++; if ({gc_data_oe, connected, frame_valid, frame_error} !== 4'b0000) begin
            bad++; $display("FAIL rst_mid_flags: got %b want 0000", {gc_data_oe, connected, frame_valid, frame_error});
        end
        reset = 1'b0;
        n = 0;
        while (!gc_data_oe && n < 2 * POLL) begin @(negedge clk); n++; end
        total++; if (gc_data_oe !== 1'b1) begin bad++; $display("FAIL rst_send_start: got %b want 1", gc_data_oe); end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        total++; if (gc_data_oe !== 1'b0) begin bad++; $display("FAIL rst_send_release: got %b want 0", gc_data_oe); end
        reset = 1'b0;
        @(negedge clk);
        total++; if (gc_data_oe !== 1'b0) begin bad++; $display("FAIL rst_send_idle: got %b want 0", gc_data_oe); end
    endtask

    initial begin
        test_reset();
        test_command();
        test_good_frame();
        test_update();
        test_timeout();
        test_bad_header();
        test_truncated();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
